// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: cause codes, pc select values,
// FSM encoding and the pending/decision records passed to the priority encoder.
package trap_sequencer_pkg;

  localparam int CAUSE_W = 5;
  localparam int NUM_SRC = 5;

  localparam logic [CAUSE_W-1:0] CAUSE_ILL     = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI     = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_MSI     = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MTI     = 5'd7;

  localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
  localparam logic [1:0] PC_SEL_MTVEC = 2'b01;
  localparam logic [1:0] PC_SEL_MEPC  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAKE,
    ST_FLUSH,
    ST_HANDLER,
    ST_RET
  } state_e;

  // Field order matches the source index: bit 4 is the highest priority.
  typedef struct packed {
    logic ill;
    logic ecall;
    logic mei;
    logic msi;
    logic mti;
  } pend_t;

  typedef struct packed {
    logic               valid;
    logic               irq;
    logic [CAUSE_W-1:0] cause;
  } dec_t;

  localparam logic [NUM_SRC-1:0][CAUSE_W-1:0] SRC_CAUSE =
    {CAUSE_ILL, CAUSE_ECALL_M, CAUSE_MEI, CAUSE_MSI, CAUSE_MTI};
  localparam logic [NUM_SRC-1:0] SRC_IS_IRQ = 5'b00111;

endpackage

// File: rtl/trap_sequencer_if.sv
// Trap sequencer signal bundle: interrupt sources, CSR enables, EX commands
// in; trap/return strobes and redirect controls out.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic               ext_irq;
  logic               sw_irq;
  logic               timer_irq;
  logic               csr_meie;
  logic               csr_msie;
  logic               csr_mtie;
  logic               csr_gie;
  logic               illegal_ops_ex;
  logic               cmd_ecall_ex;
  logic               cmd_mret_ex;
  logic               stall;
  logic               trap_take;
  logic               trap_irq;
  logic [CAUSE_W-1:0] trap_cause;
  logic               mret_take;
  logic               flush_req;
  logic [1:0]         pc_sel;
  logic               in_handler;

  modport master (
    input  ext_irq, sw_irq, timer_irq, csr_meie, csr_msie, csr_mtie, csr_gie,
           illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex, stall,
    output trap_take, trap_irq, trap_cause, mret_take, flush_req, pc_sel, in_handler
  );

  modport slave (
    output ext_irq, sw_irq, timer_irq, csr_meie, csr_msie, csr_mtie, csr_gie,
           illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex, stall,
    input  trap_take, trap_irq, trap_cause, mret_take, flush_req, pc_sel, in_handler
  );
endinterface

// File: rtl/trap_sequencer_prio_enc.sv
// Combinational trap priority encoder: highest-index pending source wins and
// supplies its cause code and interrupt flag.
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  pend_t i_pend,
  output dec_t  o_dec
);

  logic [NUM_SRC-1:0] w_vec;

  assign w_vec = i_pend;

  // Ascending scan so the last (highest-priority) hit overwrites earlier ones.
  always_comb begin
    o_dec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_vec[i]) begin
        o_dec.valid = 1'b1;
        o_dec.irq   = SRC_IS_IRQ[i];
        o_dec.cause = SRC_CAUSE[i];
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: arbitrates exceptions and M-mode interrupts,
// issues the single trap-take / mret strobe and holds flush for the redirect.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int IRQ_SYNC     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  trap_sequencer_if.master bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [1:0]         r_ext_sync;
  logic [1:0]         r_sw_sync;
  logic [2:0]         r_cnt;
  logic               r_exit;
  logic               r_in_hdl;
  logic               r_irq;
  logic [CAUSE_W-1:0] r_cause;

  logic               w_ext;
  logic               w_sw;
  logic               w_irq_ok;
  pend_t              w_pend;
  dec_t               w_dec;
  logic               w_take_go;
  logic               w_ret_go;
  logic               w_trap_take;
  logic               w_mret_take;
  logic               w_flush;
  logic [1:0]         w_pc_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ext_sync <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_ext_sync <= {r_ext_sync[0], bus.ext_irq};
      r_sw_sync  <= {r_sw_sync[0],  bus.sw_irq};
    end
  end

  assign w_ext = (IRQ_SYNC != 0) ? r_ext_sync[1] : bus.ext_irq;
  assign w_sw  = (IRQ_SYNC != 0) ? r_sw_sync[1]  : bus.sw_irq;

  // Interrupts only compete from IDLE; inside a handler there is no nesting.
  assign w_irq_ok   = (r_state == ST_IDLE) & bus.csr_gie;
  assign w_pend.ill   = bus.illegal_ops_ex;
  assign w_pend.ecall = bus.cmd_ecall_ex;
  assign w_pend.mei   = w_irq_ok & w_ext & bus.csr_meie;
  assign w_pend.msi   = w_irq_ok & w_sw & bus.csr_msie;
  assign w_pend.mti   = w_irq_ok & bus.timer_irq & bus.csr_mtie;

  trap_prio_enc u_prio (
    .i_pend (w_pend),
    .o_dec  (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_go   = 1'b0;
    w_ret_go    = 1'b0;
    w_trap_take = 1'b0;
    w_mret_take = 1'b0;
    w_flush     = 1'b0;
    w_pc_sel    = PC_SEL_SEQ;
    case (r_state)
      ST_IDLE, ST_HANDLER: begin
        if (!bus.stall) begin
          if (w_dec.valid) begin
            w_take_go   = 1'b1;
            w_state_nxt = ST_TAKE;
          end else if (bus.cmd_mret_ex) begin
            w_ret_go    = 1'b1;
            w_state_nxt = ST_RET;
          end
        end
      end
      ST_TAKE: begin
        w_trap_take = 1'b1;
        w_flush     = 1'b1;
        w_pc_sel    = PC_SEL_MTVEC;
        w_state_nxt = (FLUSH_CYCLES == 1) ? ST_HANDLER : ST_FLUSH;
      end
      ST_RET: begin
        w_mret_take = 1'b1;
        w_flush     = 1'b1;
        w_pc_sel    = PC_SEL_MEPC;
        w_state_nxt = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt <= 3'd1) w_state_nxt = r_exit ? ST_IDLE : ST_HANDLER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_exit   <= 1'b0;
      r_in_hdl <= 1'b0;
      r_irq    <= 1'b0;
      r_cause  <= '0;
    end else if (w_take_go) begin
      r_cnt    <= FLUSH_LOAD;
      r_exit   <= 1'b0;
      r_in_hdl <= 1'b1;
      r_irq    <= w_dec.irq;
      r_cause  <= w_dec.cause;
    end else if (w_ret_go) begin
      r_cnt    <= FLUSH_LOAD;
      r_exit   <= 1'b1;
      r_in_hdl <= 1'b0;
    end else if (r_state == ST_FLUSH) begin
      r_cnt    <= r_cnt - 3'd1;
    end
  end

  assign bus.trap_take  = w_trap_take;
  assign bus.mret_take  = w_mret_take;
  assign bus.flush_req  = w_flush;
  assign bus.pc_sel     = w_pc_sel;
  assign bus.in_handler = r_in_hdl;
  assign bus.trap_irq   = r_irq;
  assign bus.trap_cause = r_cause;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios then random
// traffic, every cycle compared against a window-based behavioural model.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trap_sequencer_if bus();

  trap_sequencer #(.FLUSH_CYCLES(FC), .IRQ_SYNC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: m_win counts the remaining cycles of the current take/return redirect
  // window (strobe cycle plus flush tail); decisions only happen when it is 0.
  int         m_win;
  bit         m_kind_ret;
  bit         m_in_hdl;
  bit         m_irq;
  logic [4:0] m_cause;
  bit         m_es0, m_es1, m_ss0, m_ss1;
  int         n_vec, n_err;

  task automatic model_edge();
    bit ext_e, sw_e, exc, irq, ci;
    logic [4:0] c;
    if (!rst_n) begin
      m_win = 0; m_kind_ret = 0; m_in_hdl = 0; m_irq = 0; m_cause = '0;
      m_es0 = 0; m_es1 = 0; m_ss0 = 0; m_ss1 = 0;
      return;
    end
    ext_e = m_es1; sw_e = m_ss1;
    m_es1 = m_es0; m_es0 = bus.ext_irq;
    m_ss1 = m_ss0; m_ss0 = bus.sw_irq;
    exc = bus.illegal_ops_ex || bus.cmd_ecall_ex;
    irq = bus.csr_gie && ((ext_e && bus.csr_meie) || (sw_e && bus.csr_msie) ||
                          (bus.timer_irq && bus.csr_mtie));
    if (bus.illegal_ops_ex)             begin c = 5'd2;  ci = 0; end
    else if (bus.cmd_ecall_ex)          begin c = 5'd11; ci = 0; end
    else if (ext_e && bus.csr_meie)     begin c = 5'd11; ci = 1; end
    else if (sw_e && bus.csr_msie)      begin c = 5'd3;  ci = 1; end
    else                                begin c = 5'd7;  ci = 1; end
    if (m_win > 0) m_win--;
    else if (!bus.stall) begin
      if (exc || (irq && !m_in_hdl)) begin
        m_win = FC; m_kind_ret = 0; m_in_hdl = 1; m_cause = c; m_irq = ci;
      end else if (bus.cmd_mret_ex) begin
        m_win = FC; m_kind_ret = 1; m_in_hdl = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit e_take, e_mret;
    e_take = (m_win == FC) && !m_kind_ret;
    e_mret = (m_win == FC) && m_kind_ret;
    check("trap_take",  8'(bus.trap_take),  8'(e_take));
    check("mret_take",  8'(bus.mret_take),  8'(e_mret));
    check("flush_req",  8'(bus.flush_req),  8'(m_win > 0));
    check("pc_sel",     8'(bus.pc_sel),     e_take ? 8'd1 : (e_mret ? 8'd2 : 8'd0));
    check("in_handler", 8'(bus.in_handler), 8'(m_in_hdl));
    check("trap_cause", 8'(bus.trap_cause), 8'(m_cause));
    check("trap_irq",   8'(bus.trap_irq),   8'(m_irq));
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic clr_inputs();
    bus.ext_irq = 0; bus.sw_irq = 0; bus.timer_irq = 0;
    bus.csr_meie = 0; bus.csr_msie = 0; bus.csr_mtie = 0; bus.csr_gie = 0;
    bus.illegal_ops_ex = 0; bus.cmd_ecall_ex = 0; bus.cmd_mret_ex = 0; bus.stall = 0;
  endtask

  task automatic mret_pulse();
    bus.cmd_mret_ex = 1; tick(); bus.cmd_mret_ex = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clr_inputs();
    rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(2);

    // External interrupt through the synchroniser, retaken after return while held.
    bus.csr_meie = 1; bus.csr_gie = 1; bus.ext_irq = 1;
    tick(7);
    mret_pulse();
    tick(6);
    bus.ext_irq = 0;
    mret_pulse();
    tick(6);

    // Illegal op beats a simultaneous external interrupt; no nesting in handler.
    bus.illegal_ops_ex = 1; bus.ext_irq = 1;
    tick(); bus.illegal_ops_ex = 0;
    tick(6);
    mret_pulse();
    tick(6);
    bus.ext_irq = 0;
    mret_pulse();
    tick(6);

    // Timer held under stall, then released.
    bus.csr_mtie = 1; bus.timer_irq = 1; bus.stall = 1;
    tick(5);
    bus.stall = 0;
    tick(3);
    bus.timer_irq = 0;
    mret_pulse();
    tick(4);

    // Software + timer gated by gie, msie cleared inside the handler.
    bus.csr_gie = 0; bus.csr_msie = 1; bus.sw_irq = 1; bus.timer_irq = 1;
    tick(5);
    bus.csr_gie = 1;
    tick(3);
    bus.csr_msie = 0;
    tick(3);
    bus.sw_irq = 0; bus.timer_irq = 0;
    mret_pulse();
    tick(4);

    // Reset during flush, interrupt still pending afterwards.
    bus.cmd_ecall_ex = 1; bus.timer_irq = 1;
    tick(); bus.cmd_ecall_ex = 0;
    tick();
    rst_n = 0; tick(); rst_n = 1;
    tick(6);
    bus.timer_irq = 0;
    mret_pulse();
    tick(4);

    for (int i = 0; i < 3000; i++) begin
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.illegal_ops_ex = ($urandom_range(0, 15) == 0);
      bus.cmd_ecall_ex   = ($urandom_range(0, 15) == 0);
      bus.cmd_mret_ex    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0)  bus.ext_irq   = ~bus.ext_irq;
      if ($urandom_range(0, 7) == 0)  bus.sw_irq    = ~bus.sw_irq;
      if ($urandom_range(0, 7) == 0)  bus.timer_irq = ~bus.timer_irq;
      if ($urandom_range(0, 15) == 0) bus.csr_meie  = ~bus.csr_meie;
      if ($urandom_range(0, 15) == 0) bus.csr_msie  = ~bus.csr_msie;
      if ($urandom_range(0, 15) == 0) bus.csr_mtie  = ~bus.csr_mtie;
      if ($urandom_range(0, 9) == 0)  bus.csr_gie   = ~bus.csr_gie;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
